crossy_lane_engine: RTL and testbench
=====================================

Name: crossy_lane_engine

Overview:
Parametrised obstacle-lane and game-state engine for the VGA crossy-road game. It generalises the fixed three-obstacle layout to NUM_LANES lanes with alternating direction, score-dependent speed and frame-synchronous updates. It adds lives, a hit/invulnerability phase and a game-over/restart state machine. It sits between the VGA timing generator and the final colour mux; the score overlay stays external and is muxed on top of o_rgb.

Parameters:
NUM_LANES, 3, number of obstacle lanes (1..8)
OBS_W, 50, obstacle width in px
OBS_H, 30, obstacle height in px
LANE_SPACING, 150, initial vertical spacing between lanes in px
X_SPACING, 250, initial horizontal spacing between lanes in px
CHICKEN_X, 310, chicken left edge
CHICKEN_Y, 400, chicken top edge
CHICKEN_W, 30, chicken width
CHICKEN_H, 40, chicken height
SCREEN_W, 640, active width
SCREEN_H, 480, active height
STEP_Y, 10, vertical scroll per accepted move
LIVES, 3, lives at start (1..7)
HIT_FRAMES, 60, frames spent in HIT

Ports:
i_clk  in  1  pixel clock
i_rst_n  in  1  asynchronous active-low reset
i_hpos  in  10  current pixel x from VGA timing
i_vpos  in  10  current pixel y from VGA timing
i_display_on  in  1  active-video flag
i_move_btn  in  1  move button, already synchronised, level
o_rgb  out  3  pixel colour, registered
o_score  out  8  rows crossed, saturating
o_lives  out  3  remaining lives
o_state  out  2  0=PLAY, 1=HIT, 2=OVER
o_collision  out  1  one-cycle pulse when a hit is committed

Behaviour:
- Reset is asynchronous and active-low: one clock, i_clk; reset i_rst_n.
- Reset values: o_rgb=0, o_score=0, o_lives=LIVES, o_state=PLAY, o_collision=0, all flags and counters 0.
- Lane k reset position: x=(k*X_SPACING) mod SCREEN_W, y=(k*LANE_SPACING) mod SCREEN_H.
- Frame tick: a single-cycle internal pulse when i_hpos==0 && i_vpos==SCREEN_H. All position, score, lives and state updates happen only on the frame tick.
- Button input:
  - A rising edge of i_move_btn (registered previous value) sets move_pending.
  - move_pending is consumed (cleared) at the next frame tick, whether or not it is acted on.
  - Multiple edges within one frame count as a single move.
- Horizontal motion (PLAY and HIT):
  - speed = 1 + min(o_score>>3, 3).
  - Even lanes move +speed. Odd lanes move -speed.
  - Wrap modulo SCREEN_W: x+speed >= SCREEN_W gives x+speed-SCREEN_W; x < speed gives x+SCREEN_W-speed.
- Vertical motion (PLAY only, on a consumed move):
  - Every lane gets y += STEP_Y.
  - If the result >= SCREEN_H, y wraps to result-SCREEN_H and o_score increments (saturates at 255), at most +1 per frame tick.
- Pixel hit tests use unwrapped comparisons; obstacles are not drawn across the wrap seam.
  - obs_hit = any lane with hpos in [x, x+OBS_W) and vpos in [y, y+OBS_H).
  - chick_hit = hpos in [CHICKEN_X, CHICKEN_X+CHICKEN_W) and vpos in [CHICKEN_Y, CHICKEN_Y+CHICKEN_H).
- Collision:
  - hit_flag is sticky; it is set when i_display_on && obs_hit && chick_hit in PLAY.
  - hit_flag is cleared on every frame tick.
  - At a frame tick with hit_flag set: o_collision pulses, o_lives decrements, the pending move is discarded and score does not increment.
  - Next state is OVER if lives reaches 0, otherwise HIT with hit_cnt=0.
- HIT:
  - Moves are ignored and hit detection is disabled.
  - Chicken is drawn only when hit_cnt[3]==0 (blink).
  - hit_cnt increments per frame tick.
  - At hit_cnt==HIT_FRAMES-1: go to PLAY and reload all lane y to reset values.
- OVER:
  - All positions are frozen and the background is black.
  - A button edge makes the next frame tick restore all reset values (score, lives, positions) and enter PLAY.
- o_rgb, registered with 1-cycle latency from i_hpos/i_vpos, in priority order:
  - !i_display_on gives 000.
  - obs&chick gives 011.
  - obs gives 100.
  - visible chick gives 010.
  - otherwise 001 in PLAY/HIT, 000 in OVER.
- Reset asserted mid-frame or mid-HIT returns everything to reset values immediately; no stale pending move survives.

Test Plan:
- Reset, run 1 frame with no button -> lane0 x 0→1, lane1 x 250→249, lane2 x 500→501, o_score=0, o_state=0.
- Set lane0 x=639, run 1 frame -> x=0; set lane1 x=0 -> x=639; at o_score=8 speed=2, at o_score=40 speed=4.
- Three button pulses in one frame -> all y +10 exactly once; lane with y=470 plus a move -> y=0, o_score=1; o_score=255 plus a wrap -> stays 255.
- Force lane y=400, x=300 in PLAY -> o_rgb=011 at pixel (310,400) after 1 cycle, o_collision pulse at frame tick, o_lives=2, o_state=1; move in the same frame ignored; after 60 frames o_state=0 with y reloaded to 0/150/300.
- Three commits -> o_lives=0, o_state=2, background pixel o_rgb=000; button edge -> next frame o_state=0, o_lives=3, o_score=0.
- Assert i_rst_n=0 mid-HIT, asynchronously, between clock edges -> outputs at reset values before the next i_clk edge.

Source files
------------

// File: rtl/crossy_lane_engine.sv
// Obstacle-lane and game-state engine for the crossy-road VGA game.
// Lanes scroll horizontally every frame, scroll vertically on accepted moves,
// and a PLAY/HIT/OVER state machine tracks lives and restarts.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_PLAY | normal play: moves accepted, hits detected
// ST_HIT  | post-hit invulnerability, chicken blinks, moves ignored
// ST_OVER | no lives left, frozen black screen, move restarts the game
module crossy_lane_engine #(
  parameter int NUM_LANES    = 3,
  parameter int OBS_W        = 50,
  parameter int OBS_H        = 30,
  parameter int LANE_SPACING = 150,
  parameter int X_SPACING    = 250,
  parameter int CHICKEN_X    = 310,
  parameter int CHICKEN_Y    = 400,
  parameter int CHICKEN_W    = 30,
  parameter int CHICKEN_H    = 40,
  parameter int SCREEN_W     = 640,
  parameter int SCREEN_H     = 480,
  parameter int STEP_Y       = 10,
  parameter int LIVES        = 3,
  parameter int HIT_FRAMES   = 60
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [9:0] i_hpos,
  input  logic [9:0] i_vpos,
  input  logic       i_display_on,
  input  logic       i_move_btn,
  output logic [2:0] o_rgb,
  output logic [7:0] o_score,
  output logic [2:0] o_lives,
  output logic [1:0] o_state,
  output logic       o_collision
);

  typedef enum logic [1:0] {
    ST_PLAY = 2'd0,
    ST_HIT  = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  localparam logic [10:0] L_SW    = 11'(SCREEN_W);
  localparam logic [10:0] L_SH    = 11'(SCREEN_H);
  localparam logic [10:0] L_OW    = 11'(OBS_W);
  localparam logic [10:0] L_OH    = 11'(OBS_H);
  localparam logic [10:0] L_STEP  = 11'(STEP_Y);
  localparam logic [10:0] L_CX0   = 11'(CHICKEN_X);
  localparam logic [10:0] L_CX1   = 11'(CHICKEN_X + CHICKEN_W);
  localparam logic [10:0] L_CY0   = 11'(CHICKEN_Y);
  localparam logic [10:0] L_CY1   = 11'(CHICKEN_Y + CHICKEN_H);
  localparam logic [7:0]  L_HLAST = 8'(HIT_FRAMES - 1);
  localparam logic [2:0]  L_LIVES = 3'(LIVES);

  function automatic logic [9:0] f_x0(input int k);
    return 10'((k * X_SPACING) % SCREEN_W);
  endfunction

  function automatic logic [9:0] f_y0(input int k);
    return 10'((k * LANE_SPACING) % SCREEN_H);
  endfunction

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [NUM_LANES-1:0][9:0] r_x;
  logic [NUM_LANES-1:0][9:0] r_y;
  logic [NUM_LANES-1:0][9:0] w_x_nxt;
  logic [NUM_LANES-1:0][9:0] w_y_nxt;
  logic [NUM_LANES-1:0]      w_y_wrap;
  logic [NUM_LANES-1:0]      w_lane_hit;
  logic [7:0]                r_score;
  logic [2:0]                r_lives;
  logic [2:0]                w_lives_nxt;
  logic [7:0]                r_hit_cnt;
  logic [7:0]                w_hit_cnt_nxt;
  logic                      r_btn_prev;
  logic                      r_move_pending;
  logic                      r_hit_flag;
  logic [2:0]                r_rgb;
  logic [2:0]                w_rgb;
  logic                      r_collision;
  logic                      w_tick;
  logic                      w_rise;
  logic [2:0]                w_speed;
  logic                      w_obs;
  logic                      w_chick;
  logic                      w_chick_vis;
  logic                      w_move_x;
  logic                      w_move_y;
  logic                      w_reload_y;
  logic                      w_restore;
  logic                      w_commit;
  logic                      w_score_inc;

  assign w_tick = (i_hpos == 10'd0) && (i_vpos == 10'(SCREEN_H));
  assign w_rise = i_move_btn & ~r_btn_prev;
  // speed saturates at 4 once the score reaches 24
  assign w_speed = (r_score[7:5] != 3'd0) ? 3'd4 : ({1'b0, r_score[4:3]} + 3'd1);

  // Per-lane next positions with screen wrap, plus unwrapped pixel hit tests
  always_comb begin
    logic [10:0] w_xs;
    logic [10:0] w_xe;
    logic [10:0] w_sp;
    logic [10:0] w_ys;
    w_x_nxt    = r_x;
    w_y_nxt    = r_y;
    w_y_wrap   = '0;
    w_lane_hit = '0;
    w_sp       = {8'd0, w_speed};
    for (int k = 0; k < NUM_LANES; k++) begin
      w_xe = {1'b0, r_x[k]};
      w_xs = w_xe + w_sp;
      if ((k % 2) == 0) begin
        w_x_nxt[k] = (w_xs >= L_SW) ? 10'(w_xs - L_SW) : w_xs[9:0];
      end else begin
        w_x_nxt[k] = (w_xe < w_sp) ? 10'(w_xe + L_SW - w_sp) : 10'(w_xe - w_sp);
      end
      w_ys = {1'b0, r_y[k]} + L_STEP;
      w_y_wrap[k] = (w_ys >= L_SH);
      w_y_nxt[k]  = w_y_wrap[k] ? 10'(w_ys - L_SH) : w_ys[9:0];
      w_lane_hit[k] = ({1'b0, i_hpos} >= w_xe) && ({1'b0, i_hpos} < (w_xe + L_OW)) &&
                      ({1'b0, i_vpos} >= {1'b0, r_y[k]}) &&
                      ({1'b0, i_vpos} < ({1'b0, r_y[k]} + L_OH));
    end
  end

  assign w_obs   = |w_lane_hit;
  assign w_chick = ({1'b0, i_hpos} >= L_CX0) && ({1'b0, i_hpos} < L_CX1) &&
                   ({1'b0, i_vpos} >= L_CY0) && ({1'b0, i_vpos} < L_CY1);
  assign w_chick_vis = w_chick & ~((r_state == ST_HIT) & r_hit_cnt[3]);

  // Pixel colour priority: blank, overlap, obstacle, chicken, background
  always_comb begin
    w_rgb = 3'b000;
    if (!i_display_on)            w_rgb = 3'b000;
    else if (w_obs && w_chick)    w_rgb = 3'b011;
    else if (w_obs)               w_rgb = 3'b100;
    else if (w_chick_vis)         w_rgb = 3'b010;
    else if (r_state != ST_OVER)  w_rgb = 3'b001;
  end

  // Frame-tick decisions: next state and which updates to apply
  always_comb begin
    w_state_nxt   = r_state;
    w_move_x      = 1'b0;
    w_move_y      = 1'b0;
    w_reload_y    = 1'b0;
    w_restore     = 1'b0;
    w_commit      = 1'b0;
    w_score_inc   = 1'b0;
    w_lives_nxt   = r_lives;
    w_hit_cnt_nxt = r_hit_cnt;
    if (w_tick) begin
      case (r_state)
        ST_PLAY: begin
          w_move_x = 1'b1;
          if (r_hit_flag) begin
            w_commit      = 1'b1;
            w_lives_nxt   = r_lives - 3'd1;
            w_hit_cnt_nxt = 8'd0;
            w_state_nxt   = (r_lives == 3'd1) ? ST_OVER : ST_HIT;
          end else if (r_move_pending) begin
            w_move_y    = 1'b1;
            w_score_inc = |w_y_wrap;
          end
        end
        ST_HIT: begin
          w_move_x = 1'b1;
          if (r_hit_cnt == L_HLAST) begin
            w_state_nxt   = ST_PLAY;
            w_reload_y    = 1'b1;
            w_hit_cnt_nxt = 8'd0;
          end else begin
            w_hit_cnt_nxt = r_hit_cnt + 8'd1;
          end
        end
        ST_OVER: begin
          if (r_move_pending) begin
            w_restore     = 1'b1;
            w_state_nxt   = ST_PLAY;
            w_lives_nxt   = L_LIVES;
            w_hit_cnt_nxt = 8'd0;
          end
        end
        default: w_state_nxt = ST_PLAY;
      endcase
    end
  end

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_PLAY;
    else          r_state <= w_state_nxt;
  end

  // Lane positions, score, lives, button/hit tracking and registered pixel
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < NUM_LANES; k++) begin
        r_x[k] <= f_x0(k);
        r_y[k] <= f_y0(k);
      end
      r_score        <= 8'd0;
      r_lives        <= L_LIVES;
      r_hit_cnt      <= 8'd0;
      r_btn_prev     <= 1'b0;
      r_move_pending <= 1'b0;
      r_hit_flag     <= 1'b0;
      r_rgb          <= 3'b000;
      r_collision    <= 1'b0;
    end else begin
      r_btn_prev     <= i_move_btn;
      r_move_pending <= w_tick ? 1'b0 : (r_move_pending | w_rise);
      r_hit_flag     <= w_tick ? 1'b0 :
                        (r_hit_flag | (i_display_on & w_obs & w_chick & (r_state == ST_PLAY)));
      r_rgb          <= w_rgb;
      r_collision    <= w_commit;
      r_lives        <= w_lives_nxt;
      r_hit_cnt      <= w_hit_cnt_nxt;
      if (w_restore) begin
        r_score <= 8'd0;
        for (int k = 0; k < NUM_LANES; k++) begin
          r_x[k] <= f_x0(k);
          r_y[k] <= f_y0(k);
        end
      end else begin
        if (w_score_inc && (r_score != 8'hFF)) r_score <= r_score + 8'd1;
        for (int k = 0; k < NUM_LANES; k++) begin
          if (w_move_x) r_x[k] <= w_x_nxt[k];
          if (w_move_y)        r_y[k] <= w_y_nxt[k];
          else if (w_reload_y) r_y[k] <= f_y0(k);
        end
      end
    end
  end

  assign o_rgb       = r_rgb;
  assign o_score     = r_score;
  assign o_lives     = r_lives;
  assign o_state     = r_state;
  assign o_collision = r_collision;

endmodule

// File: tb/tb_crossy_lane_engine.sv
// Self-checking bench for crossy_lane_engine: directed phases with randomized
// moves/probes, compared each cycle against a frame-level game model.
module tb_crossy_lane_engine;
  localparam int NL = 3;
  localparam int SW = 640;
  localparam int SH = 480;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] hpos = '0;
  logic [9:0] vpos = '0;
  logic       disp = 1'b0;
  logic       btn = 1'b0;
  logic [2:0] rgb;
  logic [7:0] score;
  logic [2:0] lives;
  logic [1:0] state;
  logic       col;

  crossy_lane_engine dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_hpos(hpos), .i_vpos(vpos),
    .i_display_on(disp), .i_move_btn(btn), .o_rgb(rgb), .o_score(score),
    .o_lives(lives), .o_state(state), .o_collision(col)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int mx[NL];
  int my[NL];
  int mscore, mlives, mstate, mhc;
  bit mpend, mflag, mprev;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < NL; k++) begin
      mx[k] = (k * 250) % SW;
      my[k] = (k * 150) % SH;
    end
    mscore = 0; mlives = 3; mstate = 0; mhc = 0;
    mpend = 0; mflag = 0; mprev = 0;
  endfunction

  function automatic bit in_obs(input int h, input int v);
    for (int k = 0; k < NL; k++)
      if (h >= mx[k] && h < mx[k] + 50 && v >= my[k] && v < my[k] + 30) return 1;
    return 0;
  endfunction

  function automatic bit in_chk(input int h, input int v);
    return (h >= 310 && h < 340 && v >= 400 && v < 440);
  endfunction

  function automatic int exp_rgb(input int h, input int v, input bit d);
    bit o, c, vis;
    if (!d) return 0;
    o = in_obs(h, v);
    c = in_chk(h, v);
    vis = c && !(mstate == 1 && ((mhc / 8) % 2) == 1);
    if (o && c) return 3;
    if (o) return 4;
    if (vis) return 2;
    return (mstate == 2) ? 0 : 1;
  endfunction

  function automatic void slide(input int sp);
    for (int k = 0; k < NL; k++)
      mx[k] = (k % 2 == 0) ? (mx[k] + sp) % SW : (mx[k] - sp + SW) % SW;
  endfunction

  // One frame of game rules, applied at the frame tick
  function automatic void model_frame();
    int sp;
    bit any;
    sp = 1 + ((mscore / 8 < 3) ? mscore / 8 : 3);
    if (mstate == 0) begin
      slide(sp);
      if (mflag) begin
        mlives--;
        mstate = (mlives == 0) ? 2 : 1;
        mhc = 0;
      end else if (mpend) begin
        any = 0;
        for (int k = 0; k < NL; k++) begin
          my[k] += 10;
          if (my[k] >= SH) begin my[k] -= SH; any = 1; end
        end
        if (any && mscore < 255) mscore++;
      end
    end else if (mstate == 1) begin
      slide(sp);
      if (mhc == 59) begin
        mstate = 0;
        for (int k = 0; k < NL; k++) my[k] = (k * 150) % SH;
      end else mhc++;
    end else if (mpend) begin
      model_reset();
    end
  endfunction

  task automatic cyc(input int h, input int v, input bit d, input bit b);
    int erg;
    bit tick, ecol;
    @(negedge clk);
    hpos = 10'(h); vpos = 10'(v); disp = d; btn = b;
    tick = (h == 0 && v == SH);
    erg = exp_rgb(h, v, d);
    ecol = tick && mflag;
    if (tick) begin
      model_frame();
      mpend = 0; mflag = 0;
    end else begin
      if (b && !mprev) mpend = 1;
      if (d && mstate == 0 && in_obs(h, v) && in_chk(h, v)) mflag = 1;
    end
    mprev = b;
    @(posedge clk); #1;
    chk("rgb", rgb, erg);
    chk("collision", col, ecol);
    chk("score", score, mscore);
    chk("lives", lives, mlives);
    chk("state", state, mstate);
    if (tick)
      for (int k = 0; k < NL; k++) begin
        chk("lane_x", dut.r_x[k], mx[k]);
        chk("lane_y", dut.r_y[k], my[k]);
      end
  endtask

  task automatic frame(input bit mv, input bit pr, input int ph, input int pv);
    if (mv) begin cyc(1, 1, 0, 1); cyc(1, 1, 0, 0); end
    if (pr) cyc(ph, pv, 1, 0);
    cyc(0, SH, 0, 0);
  endtask

  function automatic bit find_ov(output int h, output int v);
    int lx, rx, ly, ry;
    h = 0; v = 0;
    for (int k = 0; k < NL; k++) begin
      lx = (mx[k] > 310) ? mx[k] : 310;
      rx = (mx[k] + 50 < 340) ? mx[k] + 50 : 340;
      ly = (my[k] > 400) ? my[k] : 400;
      ry = (my[k] + 30 < 440) ? my[k] + 30 : 440;
      if (lx < rx && ly < ry) begin h = lx; v = ly; return 1; end
    end
    return 0;
  endfunction

  function automatic bit lane_in_window();
    for (int k = 0; k < NL; k++) if (my[k] > 370 && my[k] < 440) return 1;
    return 0;
  endfunction

  // Steer the game into a collision and keep playing until target state
  task automatic chase(input int target, input int budget);
    int h, v, n;
    n = 0;
    while (mstate != target && n < budget) begin
      n++;
      if (find_ov(h, v)) begin
        if (mstate == 0) begin
          cyc(1, 1, 0, 1); cyc(1, 1, 0, 0);
          cyc(h, v, 1, 0);
          chk("rgb_overlap", rgb, 3);
          cyc(0, SH, 0, 0);
          chk("hit_pulse", col, 1);
        end else frame(1, 1, h, v);
      end else if (mstate == 0 && lane_in_window()) frame(0, 0, 0, 0);
      else frame(1, 0, 0, 0);
    end
    chk("chase_state", state, target);
  endtask

  initial begin
    int pre[NL];
    int ph, pv, n, fh, fv;
    bit s8, s40;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_rgb", rgb, 0);
    chk("rst_score", score, 0);
    chk("rst_lives", lives, 3);
    chk("rst_state", state, 0);
    chk("rst_col", col, 0);
    @(negedge clk) rst_n = 1'b1;

    cyc(0, SH, 0, 0);
    chk("x0_first", dut.r_x[0], 1);
    chk("x1_first", dut.r_x[1], 249);
    chk("x2_first", dut.r_x[2], 501);
    repeat (638) cyc(0, SH, 0, 0);
    chk("x0_edge", dut.r_x[0], 639);
    cyc(0, SH, 0, 0);
    chk("x0_wrap", dut.r_x[0], 0);

    for (int k = 0; k < NL; k++) pre[k] = my[k];
    cyc(1, 1, 0, 1); cyc(1, 1, 0, 0); cyc(1, 1, 0, 1);
    cyc(1, 1, 0, 0); cyc(1, 1, 0, 1); cyc(1, 1, 0, 0);
    cyc(0, SH, 0, 0);
    for (int k = 0; k < NL; k++) chk("triple_move_y", dut.r_y[k], (pre[k] + 10) % SH);

    for (int i = 0; i < 300; i++) begin
      ph = $urandom_range(0, SW - 1);
      pv = $urandom_range(0, SH - 1);
      frame(1'($urandom_range(0, 1)), !(in_obs(ph, pv) && in_chk(ph, pv)), ph, pv);
    end

    n = 0; s8 = 0; s40 = 0;
    while (mscore < 255 && n < 6000) begin
      n++;
      if (mscore == 8 && !s8) begin
        s8 = 1; pre[0] = mx[0];
        frame(0, 0, 0, 0);
        chk("speed_at_8", dut.r_x[0], (pre[0] + 2) % SW);
      end else if (mscore == 40 && !s40) begin
        s40 = 1; pre[0] = mx[0];
        frame(0, 0, 0, 0);
        chk("speed_at_40", dut.r_x[0], (pre[0] + 4) % SW);
      end else frame(1, 0, 0, 0);
    end
    repeat (60) frame(1, 0, 0, 0);
    chk("score_sat", score, 255);

    chase(1, 3000);
    chk("first_hit_lives", lives, 2);
    chk("first_hit_state", state, 1);
    repeat (59) frame(1, 0, 0, 0);
    chk("hit_still", state, 1);
    frame(1, 0, 0, 0);
    chk("hit_exit", state, 0);
    chk("reload_y0", dut.r_y[0], 0);
    chk("reload_y1", dut.r_y[1], 150);
    chk("reload_y2", dut.r_y[2], 300);

    chase(2, 4000);
    chk("over_lives", lives, 0);
    fh = 0; fv = 0;
    for (int h = 0; h < SW; h += 37)
      if (!in_obs(h, 5) && !in_chk(h, 5)) begin fh = h; fv = 5; break; end
    cyc(fh, fv, 1, 0);
    chk("over_bg", rgb, 0);
    frame(1, 0, 0, 0);
    chk("restart_state", state, 0);
    chk("restart_lives", lives, 3);
    chk("restart_score", score, 0);

    chase(1, 3000);
    repeat (5) frame(0, 0, 0, 0);
    cyc(1, 1, 0, 1); cyc(1, 1, 0, 0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("arst_rgb", rgb, 0);
    chk("arst_score", score, 0);
    chk("arst_lives", lives, 3);
    chk("arst_state", state, 0);
    chk("arst_col", col, 0);
    chk("arst_pending", dut.r_move_pending, 0);
    btn = 1'b0;
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    frame(0, 0, 0, 0);
    chk("post_rst_y1", dut.r_y[1], 150);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
